// File: rtl/rename_tbl_ckpt.sv
// rtl/rename_tbl_ckpt.sv - register-status (rename) table with circular branch checkpoints
// One-cycle mispredict recovery: the whole table is restored from a live checkpoint slot.
module rename_tbl_ckpt #(
   parameter int NREG   = 32,
   parameter int REG_W  = 5,
   parameter int TAG_W  = 4,
   parameter int NCKPT  = 4,
   parameter int CKPT_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iss_valid,
   input  logic [REG_W-1:0]  iss_rd,
   input  logic [TAG_W-1:0]  iss_tag,
   input  logic [REG_W-1:0]  rs1,
   input  logic [REG_W-1:0]  rs2,
   output logic [TAG_W-1:0]  qj,
   output logic [TAG_W-1:0]  qk,
   input  logic              cm_valid,
   input  logic [REG_W-1:0]  cm_rd,
   input  logic [TAG_W-1:0]  cm_tag,
   input  logic              ckpt_save,
   output logic [CKPT_W-1:0] ckpt_id,
   input  logic              ckpt_release,
   input  logic              flush,
   input  logic [CKPT_W-1:0] flush_id,
   output logic              ckpt_full,
   output logic              ckpt_empty,
   output logic              err
);

   localparam logic [CKPT_W:0] CNT_FULL = (CKPT_W+1)'(NCKPT);

   logic [TAG_W-1:0]  tbl    [NREG];
   logic [TAG_W-1:0]  n_tbl  [NREG];
   logic [TAG_W-1:0]  ckpt   [NCKPT][NREG];
   logic [TAG_W-1:0]  n_ckpt [NCKPT][NREG];
   logic [CKPT_W-1:0] head, tail, n_head, n_tail;
   logic [CKPT_W:0]   count, n_count;
   logic              err_q, n_err;

   logic              cm_hit;
   logic [CKPT_W-1:0] flush_off, slot_off;
   logic              flush_ok, acc_rel, acc_save;

   // Commit bypass: a commit that retires the tag a source waits on makes it ready now.
   assign qj = (rs1 == '0 || (cm_valid && cm_rd == rs1 && tbl[rs1] == cm_tag)) ? '0 : tbl[rs1];
   assign qk = (rs2 == '0 || (cm_valid && cm_rd == rs2 && tbl[rs2] == cm_tag)) ? '0 : tbl[rs2];

   assign ckpt_id    = tail;
   assign ckpt_full  = (count == CNT_FULL);
   assign ckpt_empty = (count == '0);
   assign err        = err_q;

   assign cm_hit    = cm_valid && (cm_rd != '0);
   assign flush_off = flush_id - head;
   assign flush_ok  = flush && ({1'b0, flush_off} < count);
   assign acc_rel   = ckpt_release && (count != '0);
   assign acc_save  = ckpt_save && ((count != CNT_FULL) || acc_rel);

   always_comb begin
      n_tbl    = tbl;
      n_ckpt   = ckpt;
      n_head   = head;
      n_tail   = tail;
      n_count  = count;
      n_err    = 1'b0;
      slot_off = '0;

      for (int s = 0; s < NCKPT; s++) begin
         slot_off = CKPT_W'(s) - head;
         if (({1'b0, slot_off} < count) && cm_hit && ckpt[s][cm_rd] == cm_tag)
            n_ckpt[s][cm_rd] = '0;
      end

      if (flush_ok) begin
         n_tbl = ckpt[flush_id];
         if (cm_hit && ckpt[flush_id][cm_rd] == cm_tag)
            n_tbl[cm_rd] = '0;
         n_tail  = flush_id + CKPT_W'(1);
         n_count = {1'b0, flush_off} + (CKPT_W+1)'(1);
      end else begin
         if (flush)
            n_err = 1'b1;
         if (cm_hit && tbl[cm_rd] == cm_tag)
            n_tbl[cm_rd] = '0;
         // Issue is applied after commit so it wins on a same-register collision.
         if (iss_valid && iss_rd != '0)
            n_tbl[iss_rd] = iss_tag;
         if (ckpt_release && !acc_rel)
            n_err = 1'b1;
         if (ckpt_save && !acc_save)
            n_err = 1'b1;
         if (acc_rel)
            n_head = head + CKPT_W'(1);
         if (acc_save) begin
            n_ckpt[tail] = n_tbl;
            n_tail       = tail + CKPT_W'(1);
         end
         n_count = count + (CKPT_W+1)'(acc_save) - (CKPT_W+1)'(acc_rel);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            tbl[r] <= '0;
            for (int s = 0; s < NCKPT; s++)
               ckpt[s][r] <= '0;
         end
         head  <= '0;
         tail  <= '0;
         count <= '0;
         err_q <= 1'b0;
      end else begin
         tbl   <= n_tbl;
         ckpt  <= n_ckpt;
         head  <= n_head;
         tail  <= n_tail;
         count <= n_count;
         err_q <= n_err;
      end
   end

endmodule

// File: doc/rename_tbl_ckpt.md
Name: rename_tbl_ckpt

Overview:
Parametrised register-status (rename) table for the Tomasulo/ROB core. Records which reservation-station tag each architectural register waits on, and provides source tags Qj/Qk at issue. Clears an entry at ROB commit only if the entry still holds the committing tag. Adds a circular buffer of branch checkpoints so a mispredict flush restores the table in one cycle.

Parameters:
NREG, 32, number of architectural registers; register 0 is hardwired ready.
REG_W, 5, register index width, clog2(NREG).
TAG_W, 4, RS tag width; tag 0 means "value valid in register file".
NCKPT, 4, number of checkpoint slots, power of 2.
CKPT_W, 2, checkpoint id width, clog2(NCKPT).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active high
iss_valid  in  1  instruction issuing this cycle
iss_rd  in  REG_W  destination register of issuing instruction
iss_tag  in  TAG_W  RS tag assigned to issuing instruction
rs1  in  REG_W  source 1 index
rs2  in  REG_W  source 2 index
qj  out  TAG_W  tag for rs1, combinational
qk  out  TAG_W  tag for rs2, combinational
cm_valid  in  1  ROB commit this cycle
cm_rd  in  REG_W  dest field of committing ROB entry
cm_tag  in  TAG_W  from field of committing ROB entry
ckpt_save  in  1  take checkpoint (branch issuing)
ckpt_id  out  CKPT_W  slot that a save this cycle will use (tail)
ckpt_release  in  1  oldest branch resolved correctly; free head slot
flush  in  1  mispredict; restore from flush_id
flush_id  in  CKPT_W  checkpoint to restore
ckpt_full  out  1  all NCKPT slots live
ckpt_empty  out  1  no live slots
err  out  1  one-cycle pulse on protocol violation

Behaviour:
- State: tbl[NREG] of TAG_W bits, ckpt[NCKPT][NREG], head, tail, count (0..NCKPT).
- Reset: all tbl and ckpt entries 0, head=tail=count=0, ckpt_full=0, ckpt_empty=1, err=0.
- Reads: qj/qk = tbl[rs] with commit bypass. If cm_valid, cm_rd==rs, and tbl[rs]==cm_tag, the output is 0. A same-cycle issue does not affect qj/qk, because sources are read before the destination is renamed. rs==0 always returns 0.
- Next-state table N, normal cycle:
  - A commit clears tbl[cm_rd] to 0 only if tbl[cm_rd]==cm_tag. A stale commit is ignored.
  - An issue with iss_rd!=0 writes N[iss_rd]=iss_tag. If iss_rd==cm_rd, the issue wins.
  - Writes to register 0 are dropped.
- Commit on checkpoints: the same conditional clear applies to every live checkpoint slot, each comparing its own entry against cm_tag.
- Save, when not full: ckpt[tail] <= N, i.e. the snapshot includes this cycle's issue and commit. Then tail++ with wrap and count++.
- Save while full: ignored and err pulses.
- Release, when not empty: head++ with wrap and count--.
- Release while empty: ignored and err pulses.
- Save and release in the same cycle: both take effect and count is unchanged. When full, the release is processed first, so the save is accepted.
- Flush, when flush_id is live (within head..tail-1 modulo NCKPT):
  - tbl <= ckpt[flush_id], with a same-cycle commit's conditional clear applied on top.
  - iss_valid, ckpt_save and ckpt_release are ignored that cycle.
  - tail <= flush_id+1 (wrap), and count is recomputed as (flush_id-head+1) mod NCKPT; a value of 0 means NCKPT.
- Flush with a non-live flush_id, or while empty: ignored and err pulses.
- Flags: ckpt_full = (count==NCKPT), ckpt_empty = (count==0), both registered from count. ckpt_id = tail.
- err: registered, asserted for exactly one cycle after the violating cycle.
- rst asserted mid-operation overrides all inputs that cycle.

Test Plan:
- Reset, then iss r5 tag 3 -> next cycle rs1=5 gives qj=3; commit r5 tag 3 -> qj=0 in the same cycle via bypass and after the edge.
- Issue r7 tag 2, then r7 tag 6, then commit r7 tag 2 -> table stays 6 (stale commit ignored).
- Same cycle: iss r4 tag 9 and commit r4 tag 1 where tbl[4]=1 -> tbl[4]=9. iss r0 tag 5 -> qj for rs1=0 stays 0.
- Save at ckpt 0 with r3=4, then issue r3=7 and r8=5, then flush flush_id=0 -> r3=4, r8=0, count=1, tail=1, ckpt_id=1.
- Four saves -> ckpt_full=1; a fifth save -> err pulse and state unchanged; release plus save in the same cycle -> accepted, count stays 4, head and tail both advance.
- Save with r2=5, then commit r2 tag 5, then flush to that checkpoint -> r2=0 (commit cleared the checkpoint copy); flush to a non-live id -> err pulse, no change.
